// File: rtl/tone_pkg.sv
// ----------------------------------------------------------------------------
// tone_pkg
// Shared types and constants for the tone decoder.
//   tone_state_e       : burst tracking state (IDLE, ARMED, TRACK)
//   DEF_CNT_W          : default width of the period and silence counters
//   DEF_DUR_W          : default width of the burst-length counter
//   DEF_MIN_PERIOD     : rises closer than this to the last accepted rise
//                        are treated as glitches
//   DEF_SILENCE_CYCLES : edge-free cycles that close a burst
//   JUMP_TONE_PERIOD   : period of the jump sound effect, in pixel clocks
// ----------------------------------------------------------------------------
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2
    } tone_state_e;

    localparam int DEF_CNT_W          = 17;
    localparam int DEF_DUR_W          = 24;
    localparam int DEF_MIN_PERIOD     = 64;
    localparam int DEF_SILENCE_CYCLES = 100000;

    localparam int JUMP_TONE_PERIOD   = 28523;

endpackage

// File: rtl/tone_decoder_edge_sync.sv
// ----------------------------------------------------------------------------
// edge_sync
// Three-flop synchronizer with rise/fall/edge decode for a slow asynchronous
// 1-bit line (audio net, push buttons).
//   clk    : sampling clock
//   reset  : synchronous, active-high; clears all three flops
//   sig_i  : asynchronous input line
//   rise_o : one-cycle pulse, synchronized line went 0 -> 1
//   fall_o : one-cycle pulse, synchronized line went 1 -> 0
//   edge_o : rise_o | fall_o
// ----------------------------------------------------------------------------
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // s1/s2 resolve metastability; s3 is the one-cycle-old copy of s2 that
    // the edge decode compares against. Clearing them in reset means a line
    // held high through reset shows up as a rise once reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge decode is purely combinational so the consumer sees the pulse in
    // the same cycle s2 changes.
    always_comb begin
        rise_o = s2_q & ~s3_q;
        fall_o = ~s2_q & s3_q;
        edge_o = rise_o | fall_o;
    end

endmodule

// File: rtl/tone_decoder.sv
// ----------------------------------------------------------------------------
// tone_decoder
// Measures the 1-bit square-wave sound-effect line: per-cycle tone period,
// burst length and number of cycles in a burst.
//   clk          : pixel clock
//   reset        : synchronous, active-high
//   audio_in     : square-wave audio line (asynchronous)
//   period_out   : last rising-to-rising period in cycles, held
//   period_valid : one-cycle pulse when period_out updates
//   burst_active : high while a burst is in progress
//   burst_len    : cycles from first accepted rise to last edge of the burst
//   burst_cycles : accepted rises in the last burst, saturating at 65535
//   burst_done   : one-cycle pulse when burst_len / burst_cycles update
// ----------------------------------------------------------------------------
module tone_decoder
    import tone_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int DUR_W          = DEF_DUR_W,
    parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
    parameter int SILENCE_CYCLES = DEF_SILENCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             audio_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             burst_active,
    output logic [DUR_W-1:0] burst_len,
    output logic [15:0]      burst_cycles,
    output logic             burst_done
);

    localparam logic [CNT_W:0]   MIN_P    = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] SIL_LAST = CNT_W'(SILENCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SIL_HOLD = CNT_W'(SILENCE_CYCLES);

    logic rise;
    logic fall;
    logic anyEdge;

    tone_state_e      state_q,        state_d;
    logic [CNT_W-1:0] periodCnt_q,    periodCnt_d;
    logic [CNT_W-1:0] silenceCnt_q,   silenceCnt_d;
    logic [DUR_W-1:0] burstCnt_q,     burstCnt_d;
    logic [DUR_W-1:0] lastEdge_q,     lastEdge_d;
    logic [15:0]      cycAcc_q,       cycAcc_d;
    logic [CNT_W-1:0] periodOut_q,    periodOut_d;
    logic             periodValid_q,  periodValid_d;
    logic [DUR_W-1:0] burstLen_q,     burstLen_d;
    logic [15:0]      burstCycles_q,  burstCycles_d;
    logic             burstDone_q,    burstDone_d;

    logic [CNT_W:0]   periodNext;
    logic             periodSat;
    logic [CNT_W-1:0] periodInc;
    logic [DUR_W-1:0] burstInc;
    logic             riseOk;
    logic             silenceTimeout;

    edge_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (audio_in),
        .rise_o (rise),
        .fall_o (fall),
        .edge_o (anyEdge)
    );

    // Counter arithmetic shared by the FSM. periodNext is one bit wider so
    // the "count + 1" distance never wraps; a saturated counter therefore
    // always clears the glitch threshold but has no trustworthy period.
    // burstInc doubles as the last-edge snapshot, since count + 1 is the
    // distance from the first rise to an edge seen in this cycle.
    always_comb begin
        periodNext     = {1'b0, periodCnt_q} + 1'b1;
        periodSat      = &periodCnt_q;
        periodInc      = periodSat ? periodCnt_q : periodCnt_q + 1'b1;
        burstInc       = (&burstCnt_q) ? burstCnt_q : burstCnt_q + 1'b1;
        riseOk         = rise && (periodNext >= MIN_P);
        silenceTimeout = (state_q != IDLE) && !anyEdge
                         && (silenceCnt_q == SIL_LAST);
    end

    // Next-state and datapath logic. Counters free-run by default; the FSM
    // only overrides them on accepted rises and at burst end. Glitch rises
    // fall through to the defaults, so they only clear the silence timer and
    // refresh the last-edge snapshot.
    always_comb begin
        state_d       = state_q;
        periodCnt_d   = periodInc;
        burstCnt_d    = burstInc;
        silenceCnt_d  = anyEdge ? '0
                        : ((silenceCnt_q >= SIL_HOLD) ? silenceCnt_q
                                                      : silenceCnt_q + 1'b1);
        lastEdge_d    = (rise | fall) ? burstInc : lastEdge_q;
        cycAcc_d      = cycAcc_q;
        periodOut_d   = periodOut_q;
        periodValid_d = 1'b0;
        burstLen_d    = burstLen_q;
        burstCycles_d = burstCycles_q;
        burstDone_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d     = ARMED;
                    periodCnt_d = '0;
                    burstCnt_d  = '0;
                    lastEdge_d  = '0;
                    cycAcc_d    = 16'd1;
                end
            end

            ARMED, TRACK: begin
                if (riseOk) begin
                    state_d     = TRACK;
                    periodCnt_d = '0;
                    cycAcc_d    = (&cycAcc_q) ? cycAcc_q : cycAcc_q + 16'd1;
                    if (!periodSat) begin
                        periodOut_d   = periodNext[CNT_W-1:0];
                        periodValid_d = 1'b1;
                    end
                end else if (silenceTimeout) begin
                    state_d       = IDLE;
                    burstDone_d   = 1'b1;
                    burstLen_d    = lastEdge_q;
                    burstCycles_d = cycAcc_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any burst in flight without
    // reporting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            periodCnt_q   <= '0;
            silenceCnt_q  <= '0;
            burstCnt_q    <= '0;
            lastEdge_q    <= '0;
            cycAcc_q      <= '0;
            periodOut_q   <= '0;
            periodValid_q <= 1'b0;
            burstLen_q    <= '0;
            burstCycles_q <= '0;
            burstDone_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            periodCnt_q   <= periodCnt_d;
            silenceCnt_q  <= silenceCnt_d;
            burstCnt_q    <= burstCnt_d;
            lastEdge_q    <= lastEdge_d;
            cycAcc_q      <= cycAcc_d;
            periodOut_q   <= periodOut_d;
            periodValid_q <= periodValid_d;
            burstLen_q    <= burstLen_d;
            burstCycles_q <= burstCycles_d;
            burstDone_q   <= burstDone_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        period_out   = periodOut_q;
        period_valid = periodValid_q;
        burst_active = (state_q != IDLE);
        burst_len    = burstLen_q;
        burst_cycles = burstCycles_q;
        burst_done   = burstDone_q;
    end

endmodule

// File: tb/tb_tone_decoder.sv
// ----------------------------------------------------------------------------
// tb_tone_decoder
// Self-checking bench for tone_decoder. The silence window is shortened to
// keep run time small; the jump tone is scaled down by 100 for the same
// reason (period 285 = JUMP_TONE_PERIOD / 100).
// ----------------------------------------------------------------------------
module tb_tone_decoder;
    import tone_pkg::*;

    localparam int CW   = 17;
    localparam int DW   = 24;
    localparam int MINP = 64;
    localparam int SIL  = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          audio_in;
    logic [CW-1:0] period_out;
    logic          period_valid;
    logic          burst_active;
    logic [DW-1:0] burst_len;
    logic [15:0]   burst_cycles;
    logic          burst_done;

    int compared   = 0;
    int mismatched = 0;
    int cycleNo    = 0;

    typedef struct {
        int len;
        int cyc;
        int edgeNo;
    } bd_t;

    int  pvPeriods[$];
    bd_t bdQ[$];

    typedef struct {
        int highCyc;
        int lowCyc;
        int nPer;
        int expPv;
        int expPeriod;
        int expCycles;
        int expLen;
    } vec_t;

    vec_t vecs[5];

    tone_decoder #(
        .CNT_W          (CW),
        .DUR_W          (DW),
        .MIN_PERIOD     (MINP),
        .SILENCE_CYCLES (SIL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .audio_in     (audio_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .burst_active (burst_active),
        .burst_len    (burst_len),
        .burst_cycles (burst_cycles),
        .burst_done   (burst_done)
    );

    // Free-running clock; cycleNo is the number of rising edges so far.
    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Record every pulse on the falling edge, away from the active edge.
    always @(negedge clk) begin
        bd_t r;
        if (period_valid === 1'b1) pvPeriods.push_back(int'(period_out));
        if (burst_done === 1'b1) begin
            r.len    = int'(burst_len);
            r.cyc    = int'(burst_cycles);
            r.edgeNo = cycleNo;
            bdQ.push_back(r);
        end
    end

    // Compare one value and report it if it differs.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Hold the audio line at v for n rising edges, returning 1 time unit
    // after the last one.
    task automatic hold(input logic v, input int n);
        audio_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Play n periods of high h / low l, ending on the last high phase.
    task automatic applyStimulus(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            hold(1'b1, h);
            if (p < n - 1) hold(1'b0, l);
        end
    endtask

    // Finish a burst with silence and check its single burst_done report.
    task automatic closeAndCheck(input string name, input int expCycles,
                                 input int expLen);
        int fallEdge;
        fallEdge = cycleNo + 1;
        hold(1'b0, SIL + 20);
        checkOutput({name, ".doneCount"}, bdQ.size(), 1);
        if (bdQ.size() > 0) begin
            checkOutput({name, ".burstCycles"}, bdQ[0].cyc, expCycles);
            checkOutput({name, ".burstLen"}, bdQ[0].len, expLen);
            checkOutput({name, ".doneEdge"}, bdQ[0].edgeNo, fallEdge + 2 + SIL);
        end
        checkOutput({name, ".activeAfter"}, burst_active, 0);
    endtask

    initial begin
        int bad;
        int fallA;
        int fallB;
        string nm;

        // {high, low, periods, expected pulses, period, burst_cycles, burst_len}
        vecs[0] = '{142, 143, 10, 9, 285, 10, 2707};  // scaled jump tone
        vecs[1] = '{50,  0,   1,  0, 0,   1,  50};    // single rise
        vecs[2] = '{50,  50,  4,  3, 100, 4,  350};   // plain square wave
        vecs[3] = '{32,  32,  5,  4, 64,  5,  288};   // period exactly MIN
        vecs[4] = '{31,  32,  5,  2, 126, 3,  283};   // period MIN-1: every other rise is a glitch

        // Reset with the line low: everything zero, no pulses.
        reset    = 1'b1;
        audio_in = 1'b0;
        hold(1'b0, 5);
        checkOutput("rst.period_out",   period_out,   0);
        checkOutput("rst.period_valid", period_valid, 0);
        checkOutput("rst.burst_active", burst_active, 0);
        checkOutput("rst.burst_len",    burst_len,    0);
        checkOutput("rst.burst_cycles", burst_cycles, 0);
        checkOutput("rst.burst_done",   burst_done,   0);
        checkOutput("rst.pulses", pvPeriods.size() + bdQ.size(), 0);
        reset = 1'b0;
        hold(1'b0, 10);

        // Table-driven tones.
        for (int i = 0; i < 5; i++) begin
            nm = $sformatf("vec%0d", i);
            pvPeriods.delete();
            bdQ.delete();
            for (int p = 0; p < vecs[i].nPer; p++) begin
                hold(1'b1, vecs[i].highCyc);
                if (p == 0) checkOutput({nm, ".active"}, burst_active, 1);
                if (p < vecs[i].nPer - 1) hold(1'b0, vecs[i].lowCyc);
            end
            checkOutput({nm, ".pvCount"}, pvPeriods.size(), vecs[i].expPv);
            bad = 0;
            foreach (pvPeriods[k]) if (pvPeriods[k] != vecs[i].expPeriod) bad++;
            checkOutput({nm, ".badPeriods"}, bad, 0);
            closeAndCheck(nm, vecs[i].expCycles, vecs[i].expLen);
            if (vecs[i].expPv > 0)
                checkOutput({nm, ".periodHeld"}, period_out, vecs[i].expPeriod);
        end

        // Glitch: 1000-cycle wave (high 20) with a 3-cycle pulse 40 cycles
        // after rises 0 and 2, once in ARMED and once in TRACK.
        pvPeriods.delete();
        bdQ.delete();
        for (int p = 0; p < 4; p++) begin
            hold(1'b1, 20);
            if (p == 0 || p == 2) begin
                hold(1'b0, 20);
                hold(1'b1, 3);
                hold(1'b0, 957);
            end else if (p < 3) begin
                hold(1'b0, 980);
            end
        end
        checkOutput("glitch.pvCount", pvPeriods.size(), 3);
        bad = 0;
        foreach (pvPeriods[k]) if (pvPeriods[k] != 1000) bad++;
        checkOutput("glitch.badPeriods", bad, 0);
        closeAndCheck("glitch", 4, 3020);

        // Gap of SIL-1 edge-free cycles keeps one burst.
        pvPeriods.delete();
        bdQ.delete();
        applyStimulus(50, 50, 3);
        hold(1'b0, SIL);
        applyStimulus(50, 50, 2);
        checkOutput("gapKeep.pvCount", pvPeriods.size(), 4);
        if (pvPeriods.size() > 2)
            checkOutput("gapKeep.gapPeriod", pvPeriods[2], 2050);
        closeAndCheck("gapKeep", 5, 2400);

        // Gap of exactly SIL edge-free cycles splits into two bursts.
        pvPeriods.delete();
        bdQ.delete();
        applyStimulus(50, 50, 3);
        fallA = cycleNo + 1;
        hold(1'b0, SIL + 1);
        applyStimulus(50, 50, 2);
        fallB = cycleNo + 1;
        hold(1'b0, SIL + 20);
        checkOutput("gapSplit.pvCount", pvPeriods.size(), 3);
        checkOutput("gapSplit.doneCount", bdQ.size(), 2);
        if (bdQ.size() > 1) begin
            checkOutput("gapSplit.cycles0", bdQ[0].cyc, 3);
            checkOutput("gapSplit.len0", bdQ[0].len, 250);
            checkOutput("gapSplit.edge0", bdQ[0].edgeNo, fallA + 2 + SIL);
            checkOutput("gapSplit.cycles1", bdQ[1].cyc, 2);
            checkOutput("gapSplit.len1", bdQ[1].len, 150);
            checkOutput("gapSplit.edge1", bdQ[1].edgeNo, fallB + 2 + SIL);
        end

        // Reset during the 5th period discards the burst silently.
        applyStimulus(50, 50, 5);
        reset = 1'b1;
        hold(1'b0, 3);
        reset = 1'b0;
        pvPeriods.delete();
        bdQ.delete();
        checkOutput("midRst.period_out", period_out, 0);
        checkOutput("midRst.active", burst_active, 0);
        hold(1'b0, SIL + 20);
        checkOutput("midRst.noDone", bdQ.size(), 0);
        applyStimulus(50, 50, 3);
        checkOutput("midRst.pvCount", pvPeriods.size(), 2);
        closeAndCheck("midRst.fresh", 3, 250);

        // Line held high through reset counts as a rise after release.
        pvPeriods.delete();
        bdQ.delete();
        reset = 1'b1;
        hold(1'b1, 3);
        reset = 1'b0;
        hold(1'b1, 30);
        checkOutput("highRst.active", burst_active, 1);
        closeAndCheck("highRst", 1, 30);
        checkOutput("highRst.pvCount", pvPeriods.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
